// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with the result committed to hi/lo on done.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              is_div;
    logic              sign_a;
    logic              sign_b;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [PW-1:0]     acc;

    logic              in_sa;
    logic              in_sb;
    logic [WIDTH-1:0]  in_ma;
    logic [WIDTH-1:0]  in_mb;
    logic [WIDTH:0]    mul_sum;
    logic [PW-1:0]     mul_next;
    logic [WIDTH:0]    div_shift;
    logic              div_q;
    logic [WIDTH-1:0]  div_rem;
    logic [PW-1:0]     div_next;
    logic [PW-1:0]     mul_res;
    logic [WIDTH-1:0]  a_orig;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    // Operand decode at accept: sign flags only for the signed ops (op[0]==0).
    always_comb begin
        in_sa = ~op[0] & op_a[WIDTH-1];
        in_sb = ~op[0] & op_b[WIDTH-1];
        in_ma = in_sa ? WIDTH'(-op_a) : op_a;
        in_mb = in_sb ? WIDTH'(-op_b) : op_b;
    end

    // One iteration of each algorithm plus the sign-corrected final result.
    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : (WIDTH+1)'(0));
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[PW-1:WIDTH-1];
        div_q     = (div_shift >= {1'b0, mag_b});
        div_rem   = div_q ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_q};
        mul_res   = (sign_a ^ sign_b) ? PW'(-mul_next) : mul_next;
        a_orig    = sign_a ? WIDTH'(-mag_a) : mag_a;
        res_hi    = mul_res[PW-1:WIDTH];
        res_lo    = mul_res[WIDTH-1:0];
        if (is_div) begin
            if (mag_b == '0) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_hi = sign_a ? WIDTH'(-div_rem) : div_rem;
                res_lo = (sign_a ^ sign_b) ? WIDTH'(-div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
            end
        end
    end

    // Control FSM and datapath registers; hi/lo only change on the final iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        sign_a <= in_sa;
                        sign_b <= in_sb;
                        mag_a  <= in_ma;
                        mag_b  <= in_mb;
                        acc    <= op[1] ? {WIDTH'(0), in_ma} : {WIDTH'(0), in_mb};
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= is_div & (mag_b == '0);
                        hi          <= res_hi;
                        lo          <= res_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized checks of ex_muldiv_unit against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int fails  = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, output logic dz);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint          q;
        longint          r;
        logic [63:0]     res;
        dz = 1'b0;
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = ua * ub;
            default: begin
                if (b == 0) begin
                    dz  = 1'b1;
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {32'h0, 32'h8000_0000};
                end else if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Issue one op and follow it to done; b2b means we are already in the done cycle of the previous op.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit b2b, input string tag);
        logic [63:0] exp;
        logic        exp_dz;
        int          lat;
        bit          bsy_ok;
        bit          stable;
        exp = model(o, a, b, exp_dz);
        if (!b2b) @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bsy_ok = 1'b1; stable = 1'b1;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) bsy_ok = 1'b0;
            if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
            op = 2'($urandom); op_a = $urandom; op_b = $urandom;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(W));
        chk({tag, " busy_run"}, 64'(bsy_ok), 64'd1);
        chk({tag, " hilo_hold"}, 64'(stable), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
        chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dz));
        chk({tag, " busy_done"}, 64'(busy), 64'd0);
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
    endtask

    initial begin
        int dcount;
        int dlat;
        bit quiet;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; op = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minxmin");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        do_op(2'd3, 32'd100, 32'd7, 1'b0, "divu_100_7");
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
        do_op(2'd3, 32'd5, 32'd0, 1'b0, "divu_by0");
        do_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_by0");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(2'd1, 32'd3, 32'd4, 1'b0, "multu_3x4");
        do_op(2'd3, 32'd9, 32'd2, 1'b1, "divu_b2b");

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (ro[1] && $urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            do_op(ro, ra, rb, 1'b0, $sformatf("rand%0d", i));
        end

        // Second start while running must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'd1; op_a = 32'd6; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        dcount = 0; dlat = -1;
        for (int c = 0; c < 45; c++) begin
            if (c == 5) begin start = 1'b1; op = 2'd3; op_a = 32'd50; op_b = 32'd5; end
            if (c == 6) start = 1'b0;
            if (done) begin
                dcount++;
                if (dlat < 0) begin
                    dlat = c;
                    chk("restart hilo", {hi, lo}, 64'd42);
                end
            end
            @(negedge clk);
        end
        chk("restart done_count", 64'(dcount), 64'd1);
        chk("restart latency", 64'(dlat), 64'(W));

        // Reset mid-run discards the operation.
        start = 1'b1; op = 2'd3; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) quiet = 1'b0;
            @(negedge clk);
        end
        chk("midrst no_done", 64'(quiet), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
